// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART TX write port among NREQ byte producers.
// A granted requester keeps the port until its last byte is accepted or it stalls past TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DBIT    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DBIT-1:0] req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ack,
  input  logic               tx_full,
  output logic               wr_uart,
  output logic [DBIT-1:0]    w_data,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic               abort
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   own_q, own_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic [IW-1:0]   pick;
  logic            found;
  logic            accept;

  // (base + k) mod NREQ without a general divider.
  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int k);
    int j;
    j = int'(base) + k;
    if (j >= NREQ) j = j - NREQ;
    return IW'(j);
  endfunction

  // First requester at or after the rotation pointer.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[rr_index(ptr_q, k)]) begin
        found = 1'b1;
        pick  = rr_index(ptr_q, k);
      end
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    abort   = 1'b0;
    wr_uart = 1'b0;
    req_ack = '0;
    w_data  = '0;
    gnt     = '0;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (found) begin
          own_d   = pick;
          state_d = XFER;
        end
      end
      XFER: begin
        busy         = 1'b1;
        gnt[own_q]   = 1'b1;
        w_data       = req_data[own_q*DBIT +: DBIT];
        accept       = req[own_q] & ~tx_full;
        wr_uart      = accept;
        req_ack[own_q] = accept;
        if (req[own_q]) begin
          // Backpressure with req held never counts toward the timeout.
          cnt_d = '0;
          if (accept && req_last[own_q]) begin
            state_d = IDLE;
            ptr_d   = rr_index(own_q, 1);
          end
        end else if (cnt_inc == TIMEOUT_C) begin
          abort   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
          ptr_d   = rr_index(own_q, 1);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      own_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant latency, rotation, backpressure, timeout abort,
// non-interleaving and asynchronous reset, with hand-computed expected values.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DBIT = 8;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ack;
  logic                 tx_full;
  logic                 wr_uart;
  logic [DBIT-1:0]      w_data;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic                 abort;

  int vectors     = 0;
  int miscompares = 0;

  uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .TIMEOUT(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .req_ack  (req_ack),
    .tx_full  (tx_full),
    .wr_uart  (wr_uart),
    .w_data   (w_data),
    .gnt      (gnt),
    .busy     (busy),
    .abort    (abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] e_gnt, input logic e_wr,
                           input logic [7:0] e_data, input logic [3:0] e_ack, input logic e_abort);
    check({tag, ".gnt"},     32'(gnt),     32'(e_gnt));
    check({tag, ".busy"},    32'(busy),    32'(|e_gnt));
    check({tag, ".wr_uart"}, 32'(wr_uart), 32'(e_wr));
    check({tag, ".w_data"},  32'(w_data),  32'(e_data));
    check({tag, ".req_ack"}, 32'(req_ack), 32'(e_ack));
    check({tag, ".abort"},   32'(abort),   32'(e_abort));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_byte(input int i, input logic [7:0] v);
    req_data[i*DBIT +: DBIT] = v;
  endtask

  initial begin
    int seq [7];
    seq = '{0, 1, 2, 0, 1, 2, 3};

    reset_n  = 1'b0;
    req      = '0;
    req_data = '0;
    req_last = '0;
    tx_full  = 1'b0;
    #2;
    check_out("reset", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
    tick();
    reset_n = 1'b1;

    // T1: three-byte packet from requester 0
    tick();
    req = 4'b0001; set_byte(0, 8'h41); req_last = 4'b0000;
    #1 check_out("t1_grant", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
    tick();
    #1 check_out("t1_b0", 4'b0001, 1'b1, 8'h41, 4'b0001, 1'b0);
    tick(); set_byte(0, 8'h42);
    #1 check_out("t1_b1", 4'b0001, 1'b1, 8'h42, 4'b0001, 1'b0);
    tick(); set_byte(0, 8'h43); req_last = 4'b0001;
    #1 check_out("t1_b2", 4'b0001, 1'b1, 8'h43, 4'b0001, 1'b0);
    tick(); req = 4'b0000; req_last = 4'b0000;
    #1 check_out("t1_idle", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);

    // T2: rotation from reset, 1-byte packets, requester 3 joins later
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_byte(i, 8'(8'h10 + i));
    req = 4'b0111; req_last = 4'b1111;
    #1 check_out("t2_idle", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
    for (int k = 0; k < 7; k++) begin
      tick();
      #1 check_out($sformatf("t2_xfer%0d", k), 4'(1 << seq[k]), 1'b1, 8'(8'h10 + seq[k]),
                   4'(1 << seq[k]), 1'b0);
      tick();
      if (k == 3) req = 4'b1111;
      if (k == 6) req = 4'b0000;
      #1 check_out($sformatf("t2_idle%0d", k), 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
    end

    // T3: ten cycles of tx_full mid-packet, req held
    tick();
    req = 4'b0001; req_last = 4'b0000; set_byte(0, 8'hA0);
    #1 check_out("t3_grant", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
    tick();
    #1 check_out("t3_b0", 4'b0001, 1'b1, 8'hA0, 4'b0001, 1'b0);
    tick(); set_byte(0, 8'hA1); tx_full = 1'b1;
    for (int s = 0; s < 10; s++) begin
      #1 check_out($sformatf("t3_stall%0d", s), 4'b0001, 1'b0, 8'hA1, 4'b0000, 1'b0);
      tick();
    end
    tx_full = 1'b0;
    #1 check_out("t3_b1", 4'b0001, 1'b1, 8'hA1, 4'b0001, 1'b0);
    tick(); set_byte(0, 8'hA2); req_last = 4'b0001;
    #1 check_out("t3_b2", 4'b0001, 1'b1, 8'hA2, 4'b0001, 1'b0);
    tick(); req = 4'b0000; req_last = 4'b0000;
    #1 check_out("t3_idle", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);

    // T4: owner 1 drops req after two bytes; abort on the 16th low cycle
    tick();
    req = 4'b0010; set_byte(1, 8'hB0);
    #1 check_out("t4_grant", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
    tick();
    #1 check_out("t4_b0", 4'b0010, 1'b1, 8'hB0, 4'b0010, 1'b0);
    tick(); set_byte(1, 8'hB1);
    #1 check_out("t4_b1", 4'b0010, 1'b1, 8'hB1, 4'b0010, 1'b0);
    tick(); req = 4'b0001; req_last = 4'b0001; set_byte(0, 8'hC5);
    for (int n = 1; n <= 16; n++) begin
      if (n > 1) tick();
      #1 check_out($sformatf("t4_low%0d", n), 4'b0010, 1'b0, 8'hB1, 4'b0000, 1'(n == 16));
    end
    tick(); req = 4'b0011;
    #1 check_out("t4_after", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
    tick();
    #1 check_out("t4_next", 4'b0001, 1'b1, 8'hC5, 4'b0001, 1'b0);
    tick(); req = 4'b0000; req_last = 4'b0000;
    #1 check_out("t4_idle", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);

    // T5: requester 1 raised during requester 0's 4-byte packet
    tick();
    req = 4'b0001; set_byte(0, 8'hD0);
    #1 check_out("t5_grant", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
    for (int b = 0; b < 4; b++) begin
      tick();
      if (b > 0) set_byte(0, 8'(8'hD0 + b));
      if (b == 1) begin
        req = 4'b0011; req_last = 4'b0010; set_byte(1, 8'hE1);
      end
      if (b == 3) req_last = 4'b0011;
      #1 check_out($sformatf("t5_b%0d", b), 4'b0001, 1'b1, 8'(8'hD0 + b), 4'b0001, 1'b0);
    end
    tick(); req = 4'b0010; req_last = 4'b0010;
    #1 check_out("t5_idle", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
    tick();
    #1 check_out("t5_req1", 4'b0010, 1'b1, 8'hE1, 4'b0010, 1'b0);
    tick(); req = 4'b0000; req_last = 4'b0000;
    #1 check_out("t5_end", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);

    // T6: asynchronous reset mid-packet, then pointer restarts at 0
    tick();
    req = 4'b1000; set_byte(3, 8'hF0);
    #1 check_out("t6_grant", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
    tick();
    #1 check_out("t6_b0", 4'b1000, 1'b1, 8'hF0, 4'b1000, 1'b0);
    tick(); set_byte(3, 8'hF1);
    #1 check_out("t6_b1", 4'b1000, 1'b1, 8'hF1, 4'b1000, 1'b0);
    #2 reset_n = 1'b0;
    #1 check_out("t6_async", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
    tick();
    req = 4'b1001; req_last = 4'b0001; set_byte(0, 8'h60); reset_n = 1'b1;
    #1 check_out("t6_rel", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
    tick();
    #1 check_out("t6_win0", 4'b0001, 1'b1, 8'h60, 4'b0001, 1'b0);
    tick(); req = 4'b0000; req_last = 4'b0000;
    #1 check_out("t6_end", 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
